score_serve_ctrl: RTL and testbench

//  Game-flow controller downstream of the ball mover. Watches ball position plus the

---
 rtl/score_serve_ctrl_pkg.sv | 27 ++
 rtl/score_serve_ctrl_if.sv | 27 ++
 rtl/score_serve_ctrl_lfsr.sv | 22 ++
 rtl/score_serve_ctrl.sv | 155 +++++++++++++++
 tb/tb_score_serve_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_serve_ctrl_pkg.sv
// Shared types and constants for the score/serve game-flow controller.
//   state_t        game-flow states
//   X_MAX_DEFAULT  right goal column for a 64-wide field
//   ANGLE_W        width of the serve angle index
//   LFSR_W/TAPS    serve LFSR width and Galois toggle mask (x^8+x^6+x^5+x^4+1)
//   fix_angle      maps angle 0 to 1 so a serve never launches flat
package score_serve_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_t;

    localparam int X_MAX_DEFAULT = 63;
    localparam int ANGLE_W       = 3;
    localparam int LFSR_W        = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    function automatic logic [ANGLE_W-1:0] fix_angle(input logic [ANGLE_W-1:0] a);
        return (a == '0) ? ANGLE_W'(1) : a;
    endfunction

endpackage

// File: rtl/score_serve_ctrl_if.sv
// Link between the ball mover and the game-flow controller.
//   master : ball mover side  - drives frame_tick, bx, by, paddle_collision
//   slave  : controller side  - drives serve, serve_dir_x, serve_angle, ball_enable
interface score_serve_ctrl_if
    import score_serve_ctrl_pkg::*;
#(
    parameter int COORD_W = 6
);
    logic               frame_tick;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic               paddle_collision;
    logic               serve;
    logic               serve_dir_x;
    logic [ANGLE_W-1:0] serve_angle;
    logic               ball_enable;

    modport master (
        output frame_tick, bx, by, paddle_collision,
        input  serve, serve_dir_x, serve_angle, ball_enable
    );

    modport slave (
        input  frame_tick, bx, by, paddle_collision,
        output serve, serve_dir_x, serve_angle, ball_enable
    );
endinterface

// File: rtl/score_serve_ctrl_lfsr.sv
// 8-bit Galois LFSR used to randomise serve direction and angle.
//   clk, reset : clock, synchronous active-high reset (loads SEED)
//   enable     : advance one step per clock when high
//   q          : current LFSR state
module serve_lfsr
    import score_serve_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [LFSR_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (enable) begin
            q <= {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : '0);
        end
    end
endmodule

// File: rtl/score_serve_ctrl.sv
// Game-flow controller: detects goals from ball position, keeps both scores,
// sequences idle/wait/serve/play/point/over and issues the serve pulse.
//   clk, reset      : clock, synchronous active-high reset
//   start           : debounced start button (level)
//   ball            : link to the ball mover (slave side)
//   sc1, sc2        : player 1 (left) / player 2 (right) scores
//   game_over       : high while the game is over
//   winner          : 0 = player 1, 1 = player 2; valid with game_over
module score_serve_ctrl
    import score_serve_ctrl_pkg::*;
#(
    parameter int                COORD_W     = 6,
    parameter int                X_MAX       = X_MAX_DEFAULT,
    parameter int                SCORE_W     = 4,
    parameter int                WIN_SCORE   = 7,
    parameter int                SERVE_DELAY = 60,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    score_serve_ctrl_if.slave  ball,
    output logic [SCORE_W-1:0] sc1,
    output logic [SCORE_W-1:0] sc2,
    output logic               game_over,
    output logic               winner
);
    localparam int                 CNT_W   = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0]   DELAY_C = CNT_W'(SERVE_DELAY);
    localparam logic [COORD_W-1:0] X_MAX_C = COORD_W'(X_MAX);
    localparam logic [SCORE_W-1:0] WIN_C   = SCORE_W'(WIN_SCORE);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               scorer;      // 0 = player 1 scored, 1 = player 2 scored
    logic               serve_q;
    logic               dir_q;
    logic [ANGLE_W-1:0] angle_q;
    logic               en_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic               left_goal;
    logic               right_goal;
    logic [SCORE_W-1:0] sc1_next;
    logic [SCORE_W-1:0] sc2_next;
    logic               unused_bits;

    serve_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (1'b1),
        .q      (lfsr_q)
    );

    // Anything at or beyond X_MAX counts as the right goal; a paddle hit
    // on a goal column is always a save.
    always_comb begin
        left_goal  = ball.frame_tick && !ball.paddle_collision && (ball.bx == '0);
        right_goal = ball.frame_tick && !ball.paddle_collision && (ball.bx >= X_MAX_C);
        sc1_next   = (sc1 >= WIN_C) ? WIN_C : sc1 + 1'b1;
        sc2_next   = (sc2 >= WIN_C) ? WIN_C : sc2 + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            scorer    <= 1'b0;
            serve_q   <= 1'b0;
            dir_q     <= 1'b0;
            angle_q   <= ANGLE_W'(1);
            en_q      <= 1'b0;
            sc1       <= '0;
            sc2       <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            serve_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WAIT;
                        cnt   <= DELAY_C;
                        dir_q <= lfsr_q[0];
                    end
                end
                ST_WAIT: begin
                    // Counter stops at 1 and waits there for the final tick.
                    if (ball.frame_tick) begin
                        if (cnt == CNT_W'(1)) begin
                            state   <= ST_SERVE;
                            serve_q <= 1'b1;
                            angle_q <= fix_angle(lfsr_q[ANGLE_W-1:0] ^ ball.by[ANGLE_W-1:0]);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    state <= ST_PLAY;
                    en_q  <= 1'b1;
                end
                ST_PLAY: begin
                    if (left_goal || right_goal) begin
                        state  <= ST_POINT;
                        en_q   <= 1'b0;
                        scorer <= left_goal;
                    end
                end
                ST_POINT: begin
                    if (scorer) begin
                        sc2   <= sc2_next;
                        dir_q <= 1'b0;
                        if (sc2_next == WIN_C) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= DELAY_C;
                        end
                    end else begin
                        sc1   <= sc1_next;
                        dir_q <= 1'b1;
                        if (sc1_next == WIN_C) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= DELAY_C;
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        sc1       <= '0;
                        sc2       <= '0;
                        game_over <= 1'b0;
                        state     <= ST_WAIT;
                        cnt       <= DELAY_C;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ball.serve       = serve_q;
    assign ball.serve_dir_x = dir_q;
    assign ball.serve_angle = angle_q;
    assign ball.ball_enable = en_q;

    assign unused_bits = ^{ball.by[COORD_W-1:ANGLE_W], lfsr_q[LFSR_W-1:ANGLE_W]};

endmodule

// File: tb/tb_score_serve_ctrl.sv
// Randomised and directed bench for score_serve_ctrl. A game-level reference
// model runs on each rising edge and queues the serve pulses and score updates
// it predicts; a monitor on the falling edge pops and compares them.
module tb_score_serve_ctrl;
    localparam int COORD_W = 6;
    localparam int X_MAX   = 63;
    localparam int SCORE_W = 4;
    localparam int WIN     = 7;
    localparam int DELAY   = 60;
    localparam logic [7:0] SEED = 8'hA5;

    localparam int P_IDLE = 0, P_WAIT = 1, P_SERVE = 2, P_PLAY = 3, P_POINT = 4, P_OVER = 5;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [SCORE_W-1:0] sc1, sc2;
    logic               game_over, winner;

    score_serve_ctrl_if #(.COORD_W(COORD_W)) ball_if ();

    score_serve_ctrl #(
        .COORD_W(COORD_W), .X_MAX(X_MAX), .SCORE_W(SCORE_W),
        .WIN_SCORE(WIN), .SERVE_DELAY(DELAY), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ball(ball_if),
        .sc1(sc1), .sc2(sc2), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct { int cyc; bit dir; bit [2:0] ang; } serve_ev_t;
    typedef struct { int cyc; int s1; int s2; bit go; bit win; } score_ev_t;
    serve_ev_t sq[$];
    score_ev_t kq[$];

    // Reference model state
    int       cyc = 0;
    int       m_phase = P_IDLE;
    int       m_left = 0;
    int       m_scorer = 0;
    int       m_s1 = 0, m_s2 = 0;
    bit       m_go = 0, m_win = 0, m_dir = 0, m_en = 0;
    bit [2:0] m_ang = 3'd1;
    bit [7:0] m_lf = SEED;

    int ls1 = 0, ls2 = 0;
    bit lgo = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit [7:0] lfsr_step(input bit [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic bit [2:0] pick_angle(input bit [7:0] lf, input bit [5:0] y);
        bit [2:0] a;
        a = lf[2:0] ^ y[2:0];
        return (a == 3'd0) ? 3'd1 : a;
    endfunction

    task automatic model_step();
        bit [7:0] lf_old;
        int       ns;
        cyc++;
        if (reset) begin
            m_phase = P_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0;
            m_go = 0; m_win = 0; m_dir = 0; m_en = 0; m_ang = 3'd1; m_lf = SEED;
            sq.delete(); kq.delete();
            return;
        end
        lf_old = m_lf;
        m_lf   = lfsr_step(m_lf);
        case (m_phase)
            P_IDLE: if (start) begin
                m_phase = P_WAIT; m_left = DELAY; m_dir = lf_old[0];
            end
            P_WAIT: if (ball_if.frame_tick) begin
                if (m_left == 1) begin
                    m_phase = P_SERVE;
                    m_ang   = pick_angle(lf_old, ball_if.by);
                    sq.push_back('{cyc: cyc, dir: m_dir, ang: m_ang});
                end else begin
                    m_left--;
                end
            end
            P_SERVE: begin
                m_phase = P_PLAY; m_en = 1;
            end
            P_PLAY: if (ball_if.frame_tick && !ball_if.paddle_collision &&
                        (int'(ball_if.bx) == 0 || int'(ball_if.bx) >= X_MAX)) begin
                m_scorer = (int'(ball_if.bx) == 0) ? 2 : 1;
                m_phase  = P_POINT;
                m_en     = 0;
            end
            P_POINT: begin
                if (m_scorer == 1) begin
                    m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; ns = m_s1; m_dir = 1;
                end else begin
                    m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; ns = m_s2; m_dir = 0;
                end
                if (ns == WIN) begin
                    m_phase = P_OVER; m_go = 1; m_win = (m_scorer == 2);
                end else begin
                    m_phase = P_WAIT; m_left = DELAY;
                end
                kq.push_back('{cyc: cyc, s1: m_s1, s2: m_s2, go: m_go, win: m_win});
            end
            P_OVER: if (start) begin
                m_s1 = 0; m_s2 = 0; m_go = 0; m_phase = P_WAIT; m_left = DELAY;
                kq.push_back('{cyc: cyc, s1: 0, s2: 0, go: 0, win: m_win});
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compares DUT events against the queued predictions.
    initial forever begin
        serve_ev_t se;
        score_ev_t ke;
        @(negedge clk);
        if (reset) begin
            ls1 = int'(sc1); ls2 = int'(sc2); lgo = game_over;
        end else begin
            chk("ball_enable", int'(ball_if.ball_enable), int'(m_en));
            chk("serve_dir_x", int'(ball_if.serve_dir_x), int'(m_dir));
            chk("serve_angle", int'(ball_if.serve_angle), int'(m_ang));
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                chk("serve_missed", 0, 1);
                void'(sq.pop_front());
            end
            while (kq.size() > 0 && kq[0].cyc < cyc) begin
                chk("score_missed", 0, 1);
                void'(kq.pop_front());
            end
            if (ball_if.serve) begin
                if (sq.size() == 0) begin
                    chk("serve_unexpected", 1, 0);
                end else begin
                    se = sq.pop_front();
                    chk("serve_cycle", cyc, se.cyc);
                    chk("serve_ev_dir", int'(ball_if.serve_dir_x), int'(se.dir));
                    chk("serve_ev_angle", int'(ball_if.serve_angle), int'(se.ang));
                    chk("serve_angle_nonzero", int'(ball_if.serve_angle != 3'd0), 1);
                end
            end
            if (int'(sc1) != ls1 || int'(sc2) != ls2 || game_over != lgo) begin
                if (kq.size() == 0) begin
                    chk("score_unexpected", 1, 0);
                end else begin
                    ke = kq.pop_front();
                    chk("score_cycle", cyc, ke.cyc);
                    chk("score_sc1", int'(sc1), ke.s1);
                    chk("score_sc2", int'(sc2), ke.s2);
                    chk("score_game_over", int'(game_over), int'(ke.go));
                    if (ke.go) chk("score_winner", int'(winner), int'(ke.win));
                end
                ls1 = int'(sc1); ls2 = int'(sc2); lgo = game_over;
            end
        end
    end

    task automatic goto_play();
        for (int i = 0; i < 400 && m_phase != P_PLAY; i++) begin
            @(negedge clk);
            ball_if.frame_tick       = 1'b1;
            ball_if.bx               = COORD_W'(30);
            ball_if.paddle_collision = 1'b0;
            start = (m_phase == P_IDLE || m_phase == P_OVER);
        end
        start = 1'b0;
        ball_if.frame_tick = 1'b0;
        if (m_phase != P_PLAY) chk("goto_play_timeout", m_phase, P_PLAY);
    endtask

    task automatic goal(input bit right);
        ball_if.bx               = right ? COORD_W'(X_MAX) : '0;
        ball_if.paddle_collision = 1'b0;
        ball_if.frame_tick       = 1'b1;
        @(negedge clk);
        ball_if.frame_tick = 1'b0;
        ball_if.bx         = COORD_W'(30);
        @(negedge clk);
    endtask

    initial begin
        int s1_hold, s2_hold;
        ball_if.frame_tick = 1'b0;
        ball_if.bx = COORD_W'(30);
        ball_if.by = '0;
        ball_if.paddle_collision = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_serve", int'(ball_if.serve), 0);
        chk("rst_dir", int'(ball_if.serve_dir_x), 0);
        chk("rst_angle", int'(ball_if.serve_angle), 1);
        chk("rst_enable", int'(ball_if.ball_enable), 0);
        chk("rst_sc1", int'(sc1), 0);
        chk("rst_sc2", int'(sc2), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        reset = 1'b0;

        // First serve after DELAY ticks, then play
        ball_if.by = COORD_W'(5);
        goto_play();
        chk("t1_enable", int'(ball_if.ball_enable), 1);

        // Left goal: player 2 scores, serve goes toward player 1
        goal(1'b0);
        chk("t2_sc2", int'(sc2), 1);
        chk("t2_dir", int'(ball_if.serve_dir_x), 0);
        chk("t2_enable", int'(ball_if.ball_enable), 0);

        // Paddle hit on the right goal column is a save
        goto_play();
        ball_if.bx = COORD_W'(X_MAX);
        ball_if.paddle_collision = 1'b1;
        ball_if.frame_tick = 1'b1;
        @(negedge clk);
        ball_if.frame_tick = 1'b0;
        ball_if.paddle_collision = 1'b0;
        ball_if.bx = COORD_W'(30);
        @(negedge clk);
        chk("t3_save_enable", int'(ball_if.ball_enable), 1);
        chk("t3_save_sc1", int'(sc1), 0);
        goal(1'b1);
        chk("t3_sc1", int'(sc1), 1);

        // start held and bx at goal without a tick: nothing changes
        goto_play();
        s1_hold = int'(sc1); s2_hold = int'(sc2);
        start = 1'b1;
        ball_if.bx = '0;
        repeat (5) begin
            @(negedge clk);
            chk("t6_enable", int'(ball_if.ball_enable), 1);
            chk("t6_sc2", int'(sc2), s2_hold);
        end
        chk("t6_sc1", int'(sc1), s1_hold);
        start = 1'b0;
        ball_if.bx = COORD_W'(30);

        // Player 1 wins; no serve afterwards until start
        for (int g = 0; g < 20 && !m_go; g++) begin
            goto_play();
            goal(1'b1);
        end
        chk("t4_sc1", int'(sc1), WIN);
        chk("t4_game_over", int'(game_over), 1);
        chk("t4_winner", int'(winner), 0);
        ball_if.frame_tick = 1'b1;
        repeat (80) @(negedge clk);
        ball_if.frame_tick = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_restart_sc1", int'(sc1), 0);
        chk("t4_restart_sc2", int'(sc2), 0);
        chk("t4_restart_go", int'(game_over), 0);

        // Reset while waiting to serve with sc1=3
        for (int g = 0; g < 3; g++) begin
            goto_play();
            goal(1'b1);
        end
        chk("t5_pre_sc1", int'(sc1), 3);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_sc1", int'(sc1), 0);
        chk("t5_serve", int'(ball_if.serve), 0);
        chk("t5_enable", int'(ball_if.ball_enable), 0);
        reset = 1'b0;
        ball_if.frame_tick = 1'b1;
        repeat (100) @(negedge clk);
        ball_if.frame_tick = 1'b0;

        // Random play
        for (int i = 0; i < 5000; i++) begin
            int r;
            @(negedge clk);
            reset = (i == 2500);
            r = int'($urandom_range(0, 7));
            ball_if.frame_tick = 1'($urandom_range(0, 1));
            ball_if.bx = (r == 0) ? '0 : (r == 1) ? COORD_W'(X_MAX)
                                             : COORD_W'($urandom_range(1, X_MAX - 1));
            ball_if.by = COORD_W'($urandom);
            ball_if.paddle_collision = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ball_if.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        chk("serve_queue_empty", sq.size(), 0);
        chk("score_queue_empty", kq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
